board_tracker: RTL and testbench
================================

Name: board_tracker

Overview:
- Downstream consumer of the game FSM's move traffic.
- Watches human moves (hMove) and computer moves (cMove) every clock and records square occupancy on the 3x3 board.
- Rejects illegal moves, counts moves, and independently detects human win, computer win and draw.
- Its outputs drive the display/scoreboard and provide a self-check for the FSM's win output.

Parameters:
- NO_MOVE, 4'hF: reset/idle value loaded into the last-sample registers.
- MAX_MOVES, 9: board capacity; a full board with no win is a draw.

Ports:
- clock  input  1  system clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- hMove  input  4  human move; 1..9 is a square, any other value is idle.
- cMove  input  4  computer move from the FSM; 1..9 is a square, any other value is idle.
- xBoard  output  9  human occupancy; bit (k-1) set means square k is taken by the human.
- oBoard  output  9  computer occupancy; same bit mapping.
- moveCount  output  4  accepted moves, 0..9.
- hWin  output  1  human holds a line.
- cWin  output  1  computer holds a line.
- draw  output  1  board full, no win.
- gameOver  output  1  hWin | cWin | draw | locked error.
- hIllegal  output  1  one-cycle pulse: human move rejected.
- cIllegal  output  1  one-cycle pulse: computer move rejected.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high.
- Square numbering is row-major: 1 2 3 / 4 5 6 / 7 8 9.
- Win lines: 123, 456, 789, 147, 258, 369, 159, 357.
- Reset, on a clock edge with reset=1:
  - xBoard=0, oBoard=0, moveCount=0.
  - All flags 0; state=PLAY.
  - hLast=cLast=NO_MOVE.
  - Reset wins over every other event, including mid-game.
- Move event:
  - A move is a sampled value in 1..9 that differs from the previous sample (hLast/cLast).
  - hLast and cLast update every cycle, in every state.
  - A held value therefore produces exactly one event.
  - Going idle and back to the same square produces a new event.
- Latency: a move sampled at edge n updates the board and count at edge n. It is visible in cycle n+1.
- Flags: hWin, cWin and draw are combinational from the registered boards, so they are valid in the same cycle the board shows the completing move.
- States:
  - PLAY: events are processed.
  - HWIN, CWIN, DRAW: terminal; all events ignored, no illegal pulses, boards frozen.
  - ERROR: exists only with the optional feature enabled.
- Transitions out of PLAY, evaluated after the board update:
  - Human line present: go to HWIN.
  - Otherwise computer line present: go to CWIN.
  - Otherwise moveCount==9: go to DRAW.
- Legality: an event targeting an occupied square is rejected.
  - The board is unchanged and the matching *Illegal flag pulses for exactly 1 cycle.
  - moveCount is unchanged.
- Simultaneous human and computer events in one cycle:
  - The human is applied first.
  - If both target the same empty square, the human takes it and cIllegal pulses.
  - Otherwise both are applied and moveCount increases by 2.
- Win priority: if one update completes lines for both players, hWin wins; cWin is forced 0.
- Saturation: moveCount never exceeds 9. No events are accepted once the state is terminal.

Optional Feature:
- Macro: BOARD_TRACKER_ILLEGAL_LOCK_EN.
- Defined:
  - Any illegal event moves the state to ERROR and gameOver goes to 1.
  - The *Illegal flag stays high until reset; boards are frozen.
- Undefined:
  - Illegal events pulse for one cycle and are ignored; the game continues in PLAY.
  - The ERROR state is not generated.

Decomposition:
- Package board_pkg holds:
  - the state enum: PLAY, HWIN, CWIN, DRAW, ERROR;
  - constant WIN_LINES, 8 x 9-bit masks;
  - NO_MOVE;
  - function sq2mask: 4-bit square to 9-bit one-hot, 0 for idle codes.
- One sub-module, line_detect: combinational, 9-bit board in, 1-bit hasLine out. It is instanced twice, once for xBoard and once for oBoard.

Test Plan:
- Reset for 3 cycles, then hMove=6 held for 3 cycles: xBoard=9'h020 after the first edge, moveCount stays 1, no hIllegal.
- Human 1, 2, 3 with cMove 5, 9 interleaved: after the human's 3 lands, hWin=1, gameOver=1, state HWIN; a later cMove=4 is ignored and oBoard stays 9'h110.
- cMove=5 accepted, then hMove=5: hIllegal is high for exactly 1 cycle, xBoard unchanged, moveCount=1. With BOARD_TRACKER_ILLEGAL_LOCK_EN, hIllegal stays 1 and gameOver=1 until reset.
- hMove=7 and cMove=7 changing in the same cycle: xBoard bit6 set, oBoard unchanged, cIllegal pulses, moveCount=1.
- Full sequence with no line (X: 1,3,4,8,9; O: 2,5,6,7): draw=1 and moveCount=9 once the ninth move lands; hWin=cWin=0.
- Reset asserted mid-game after 4 moves: next cycle boards=0, moveCount=0, flags=0; hMove held at its old value is accepted again as a new event.

Source files
------------

// File: rtl/board_pkg.sv
// Shared types and constants for the tic-tac-toe board tracker.
// Squares are numbered row-major 1..9 and map to board bit (k-1).
package board_pkg;

  typedef enum logic [2:0] {
    PLAY  = 3'd0,
    HWIN  = 3'd1,
    CWIN  = 3'd2,
    DRAW  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [3:0] NO_MOVE   = 4'hF;
  localparam logic [3:0] MAX_MOVES = 4'd9;

  // Rows, columns, then the two diagonals.
  localparam logic [8:0] WIN_LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  function automatic logic [8:0] sq2mask(input logic [3:0] sq);
    logic [8:0] m;
    m = '0;
    if (sq >= 4'd1 && sq <= 4'd9) m[sq - 4'd1] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/line_detect.sv
// Flags whether an occupancy board holds any complete line.
// Purely combinational, zero latency; no flow control.
module line_detect
  import board_pkg::*;
(
  input  logic [8:0] board,
  output logic       hasLine
);

  always_comb begin
    hasLine = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((board & WIN_LINES[i]) == WIN_LINES[i]) hasLine = 1'b1;
    end
  end

endmodule

// File: rtl/board_tracker.sv
// Tracks board occupancy from hMove/cMove, rejects illegal moves, detects win/draw.
// A move sampled at edge n is visible in cycle n+1; no backpressure, moves are never stalled.
// Optional: BOARD_TRACKER_ILLEGAL_LOCK_EN latches any illegal move into a sticky ERROR state.
module board_tracker
  import board_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] hMove,
  input  logic [3:0] cMove,
  output logic [8:0] xBoard,
  output logic [8:0] oBoard,
  output logic [3:0] moveCount,
  output logic       hWin,
  output logic       cWin,
  output logic       draw,
  output logic       gameOver,
  output logic       hIllegal,
  output logic       cIllegal
);

  state_t     state, stateNext;
  logic [8:0] xQ, oQ, xNext, oNext;
  logic [3:0] cnt, cntNext;
  logic [3:0] hLast, cLast;
  logic       hIllQ, cIllQ, hIllNext, cIllNext;
  logic       xLine, oLine;

  logic [8:0] hMask, cMask, hTake, cTake;
  logic       hBad, cBad;
  logic [3:0] cntSum;

  line_detect uXLine (.board(xQ), .hasLine(xLine));
  line_detect uOLine (.board(oQ), .hasLine(oLine));

  // A held value is one event: only a change into 1..9 counts.
  assign hMask = (hMove != hLast) ? sq2mask(hMove) : 9'h000;
  assign cMask = (cMove != cLast) ? sq2mask(cMove) : 9'h000;

  // Human goes first, so the computer also collides with the human's new square.
  assign hBad  = |(hMask & (xQ | oQ));
  assign hTake = hBad ? 9'h000 : hMask;
  assign cBad  = |(cMask & (xQ | oQ | hTake));
  assign cTake = cBad ? 9'h000 : cMask;

  assign cntSum = cnt + {3'b000, |hTake} + {3'b000, |cTake};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PLAY;
      xQ    <= '0;
      oQ    <= '0;
      cnt   <= '0;
      hIllQ <= 1'b0;
      cIllQ <= 1'b0;
      hLast <= NO_MOVE;
      cLast <= NO_MOVE;
    end else begin
      state <= stateNext;
      xQ    <= xNext;
      oQ    <= oNext;
      cnt   <= cntNext;
      hIllQ <= hIllNext;
      cIllQ <= cIllNext;
      hLast <= hMove;
      cLast <= cMove;
    end
  end

  always_comb begin
    stateNext = state;
    xNext     = xQ;
    oNext     = oQ;
    cntNext   = cnt;
`ifdef BOARD_TRACKER_ILLEGAL_LOCK_EN
    hIllNext  = hIllQ;
    cIllNext  = cIllQ;
`else
    hIllNext  = 1'b0;
    cIllNext  = 1'b0;
`endif

    case (state)
      PLAY: begin
        // Lines are checked on the registered board, so the move that completes
        // the game already blocks any event arriving the next cycle.
        if (xLine) begin
          stateNext = HWIN;
        end else if (oLine) begin
          stateNext = CWIN;
        end else if (cnt == MAX_MOVES) begin
          stateNext = DRAW;
        end else begin
          hIllNext = hBad;
          cIllNext = cBad;
`ifdef BOARD_TRACKER_ILLEGAL_LOCK_EN
          if (hBad || cBad) begin
            stateNext = ERROR;
          end else begin
            xNext   = xQ | hTake;
            oNext   = oQ | cTake;
            cntNext = (cntSum > MAX_MOVES) ? MAX_MOVES : cntSum;
          end
`else
          xNext   = xQ | hTake;
          oNext   = oQ | cTake;
          cntNext = (cntSum > MAX_MOVES) ? MAX_MOVES : cntSum;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  assign xBoard    = xQ;
  assign oBoard    = oQ;
  assign moveCount = cnt;
  assign hWin      = xLine;
  assign cWin      = oLine & ~xLine;
  assign draw      = (cnt == MAX_MOVES) & ~xLine & ~oLine;
  assign gameOver  = hWin | cWin | draw | (state == ERROR);
  assign hIllegal  = hIllQ;
  assign cIllegal  = cIllQ;

endmodule

// File: tb/tb_board_tracker.sv
// Directed and randomized checks of board_tracker against a square-ownership model.
module tb_board_tracker;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] hMove, cMove;
  logic [8:0] xBoard, oBoard;
  logic [3:0] moveCount;
  logic       hWin, cWin, draw, gameOver, hIllegal, cIllegal;

  board_tracker dut (
    .clock(clock), .reset(reset), .hMove(hMove), .cMove(cMove),
    .xBoard(xBoard), .oBoard(oBoard), .moveCount(moveCount),
    .hWin(hWin), .cWin(cWin), .draw(draw), .gameOver(gameOver),
    .hIllegal(hIllegal), .cIllegal(cIllegal)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model: owner per square (0 empty, 1 human, 2 computer).
  int own [1:9];
  int lastH, lastC, mCnt;
  bit mHIll, mCIll, mErr;
  int LINES [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                       '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  function automatic bit has_line(input int p);
    bit r = 0;
    for (int i = 0; i < 8; i++)
      if (own[LINES[i][0]] == p && own[LINES[i][1]] == p && own[LINES[i][2]] == p) r = 1;
    return r;
  endfunction

  function automatic logic [8:0] board_of(input int p);
    logic [8:0] b = '0;
    for (int k = 1; k <= 9; k++) if (own[k] == p) b[k-1] = 1'b1;
    return b;
  endfunction

  task automatic model_tick(input int h, input int c, input bit r);
    bit over, hEv, cEv, hI, cI, hOk, cOk;
    if (r) begin
      for (int k = 1; k <= 9; k++) own[k] = 0;
      lastH = 15; lastC = 15; mCnt = 0; mHIll = 0; mCIll = 0; mErr = 0;
      return;
    end
    over = has_line(1) || has_line(2) || mCnt == 9 || mErr;
    hEv = (h >= 1 && h <= 9 && h != lastH);
    cEv = (c >= 1 && c <= 9 && c != lastC);
    hI = 0; cI = 0; hOk = 0; cOk = 0;
    if (!over) begin
      if (hEv) begin
        if (own[h] != 0) hI = 1; else hOk = 1;
      end
      if (cEv) begin
        if (own[c] != 0 || (hOk && c == h)) cI = 1; else cOk = 1;
      end
`ifdef BOARD_TRACKER_ILLEGAL_LOCK_EN
      if (hI || cI) begin
        mErr = 1; hOk = 0; cOk = 0;
      end
`endif
      if (hOk) begin own[h] = 1; mCnt++; end
      if (cOk) begin own[c] = 2; mCnt++; end
    end
`ifdef BOARD_TRACKER_ILLEGAL_LOCK_EN
    mHIll = mHIll | hI;
    mCIll = mCIll | cI;
`else
    mHIll = hI;
    mCIll = cI;
`endif
    lastH = h; lastC = c;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit lx, lo;
    lx = has_line(1);
    lo = has_line(2);
    chk("xBoard",    xBoard,           board_of(1));
    chk("oBoard",    oBoard,           board_of(2));
    chk("moveCount", 9'(moveCount),    9'(mCnt));
    chk("hWin",      9'(hWin),         9'(lx));
    chk("cWin",      9'(cWin),         9'(lo && !lx));
    chk("draw",      9'(draw),         9'(mCnt == 9 && !lx && !lo));
    chk("gameOver",  9'(gameOver),     9'(lx || lo || mCnt == 9 || mErr));
    chk("hIllegal",  9'(hIllegal),     9'(mHIll));
    chk("cIllegal",  9'(cIllegal),     9'(mCIll));
  endtask

  task automatic step(input logic [3:0] h, input logic [3:0] c, input logic r);
    hMove = h; cMove = c; reset = r;
    @(posedge clock);
    model_tick(int'(h), int'(c), r);
    #1;
    check_all();
  endtask

  initial begin
    logic [3:0] rh, rc;
    hMove = 4'd0; cMove = 4'd0; reset = 1'b1;

    // Reset, then a held human 6 is one event.
    repeat (3) step(4'd0, 4'd0, 1'b1);
    step(4'd6, 4'd0, 1'b0);
    chk("t1_x_first", xBoard, 9'h020);
    step(4'd6, 4'd0, 1'b0);
    step(4'd6, 4'd0, 1'b0);
    chk("t1_cnt_held", 9'(moveCount), 9'd1);
    chk("t1_noill", 9'(hIllegal), 9'd0);

    // Human wins on 1,2,3; later computer move ignored.
    step(4'd0, 4'd0, 1'b1);
    step(4'd1, 4'd0, 1'b0);
    step(4'd0, 4'd5, 1'b0);
    step(4'd2, 4'd0, 1'b0);
    step(4'd0, 4'd9, 1'b0);
    step(4'd3, 4'd0, 1'b0);
    chk("t2_hwin", 9'(hWin), 9'd1);
    chk("t2_over", 9'(gameOver), 9'd1);
    step(4'd0, 4'd4, 1'b0);
    step(4'd0, 4'd0, 1'b0);
    chk("t2_o_frozen", oBoard, 9'h110);

    // Human onto the computer's square.
    step(4'd0, 4'd0, 1'b1);
    step(4'd0, 4'd5, 1'b0);
    step(4'd5, 4'd0, 1'b0);
    chk("t3_hill", 9'(hIllegal), 9'd1);
    chk("t3_x", xBoard, 9'h000);
    chk("t3_cnt", 9'(moveCount), 9'd1);
    step(4'd5, 4'd0, 1'b0);
`ifdef BOARD_TRACKER_ILLEGAL_LOCK_EN
    chk("t3_hill_lock", 9'(hIllegal), 9'd1);
    chk("t3_over_lock", 9'(gameOver), 9'd1);
`else
    chk("t3_hill_pulse", 9'(hIllegal), 9'd0);
`endif

    // Same square in the same cycle: human wins it.
    step(4'd0, 4'd0, 1'b1);
    step(4'd7, 4'd7, 1'b0);
    chk("t4_x", xBoard, 9'h040);
    chk("t4_o", oBoard, 9'h000);
    chk("t4_cill", 9'(cIllegal), 9'd1);
    chk("t4_cnt", 9'(moveCount), 9'd1);

    // Draw.
    step(4'd0, 4'd0, 1'b1);
    step(4'd1, 4'd0, 1'b0); step(4'd0, 4'd2, 1'b0);
    step(4'd3, 4'd0, 1'b0); step(4'd0, 4'd5, 1'b0);
    step(4'd4, 4'd0, 1'b0); step(4'd0, 4'd6, 1'b0);
    step(4'd8, 4'd0, 1'b0); step(4'd0, 4'd7, 1'b0);
    step(4'd9, 4'd0, 1'b0);
    chk("t5_draw", 9'(draw), 9'd1);
    chk("t5_cnt", 9'(moveCount), 9'd9);
    chk("t5_nowin", 9'(hWin | cWin), 9'd0);

    // Mid-game reset with a held human move.
    step(4'd0, 4'd0, 1'b1);
    step(4'd1, 4'd2, 1'b0);
    step(4'd3, 4'd4, 1'b0);
    step(4'd3, 4'd4, 1'b1);
    chk("t6_cnt_reset", 9'(moveCount), 9'd0);
    step(4'd3, 4'd0, 1'b0);
    chk("t6_reaccept", xBoard, 9'h004);

    // Randomized games with occasional resets and held values.
    rh = 4'd0; rc = 4'd0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) rh = 4'($urandom_range(0, 11));
      if ($urandom_range(0, 1) == 0) rc = 4'($urandom_range(0, 11));
      step(rh, rc, ($urandom_range(0, 29) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
